// File: rtl/demux1_8_deser_if.sv
// Bus bundle for the 1:8 deserializer: serial input side plus word output handshake.
interface demux1_8_deser_if;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] idx;
  logic       overrun;
  logic       frame_err;

  // master: transmitter/consumer side; slave: the deserializer itself
  modport master (
    output din, din_valid, sof, dout_ready,
    input  dout, dout_valid, idx, overrun, frame_err
  );

  modport slave (
    input  din, din_valid, sof, dout_ready,
    output dout, dout_valid, idx, overrun, frame_err
  );
endinterface

// File: rtl/demux1_8_deser.sv
// Collects a serial stream driven by an 8:1 select mux back into 8-bit words,
// presented through a one-word valid/ready holding register.
module demux1_8_deser #(
  parameter int unsigned MSB_FIRST = 0
) (
  input logic              clk,
  input logic              rst,
  demux1_8_deser_if.slave  bus
);

  localparam int unsigned W         = 8;
  localparam int unsigned IW        = 3;
  localparam int unsigned FIRST_POS = (MSB_FIRST != 0) ? (W - 1) : 0;

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  part_q, part_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic [IW-1:0] bit_pos_c;
  logic [W-1:0]  word_c;
  logic          complete_c;
  logic          xfer_c;

  assign bit_pos_c = (MSB_FIRST != 0) ? (IW'(W - 1) - idx_q) : idx_q;
  assign xfer_c    = dout_valid_q & bus.dout_ready;

  // Bit collection, completion and holding-register update.
  always_comb begin
    idx_d        = idx_q;
    part_d       = part_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    complete_c   = 1'b0;
    word_c       = part_q;
    word_c[bit_pos_c] = bus.din;

    if (bus.din_valid) begin
      if (bus.sof) begin
        // sof restarts the frame even on what would be the 8th bit
        part_d                 = '0;
        part_d[IW'(FIRST_POS)] = bus.din;
        idx_d                  = IW'(1);
        frame_err_d            = (idx_q != '0);
      end else begin
        part_d = word_c;
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(W - 1)) begin
          complete_c = 1'b1;
          part_d     = '0;
        end
      end
    end

    if (xfer_c) begin
      dout_valid_d = 1'b0;
    end

    if (complete_c) begin
      if (!dout_valid_q || xfer_c) begin
        dout_d       = word_c;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      part_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      part_q       <= part_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.idx        = idx_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Bench for demux1_8_deser: LSB-first and MSB-first instances driven in lockstep,
// transferred words checked against per-instance expectation queues.
module tb_demux1_8_deser;

  logic clk;
  logic rst;

  demux1_8_deser_if bl ();
  demux1_8_deser_if bm ();

  demux1_8_deser #(.MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));
  demux1_8_deser #(.MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(bm));

  int total;
  int bad;
  logic [7:0] q_lsb[$];
  logic [7:0] q_msb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic set_in(input logic v, input logic s, input logic d);
    bl.din_valid = v; bl.sof = s; bl.din = d;
    bm.din_valid = v; bm.sof = s; bm.din = d;
  endtask

  task automatic set_ready(input logic r);
    bl.dout_ready = r;
    bm.dout_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic s, input logic d);
    set_in(1'b1, s, d);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
  endtask

  // Sends one full frame; the expected word is queued only if it will be accepted.
  task automatic send_word(input logic [7:0] w, input logic push);
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && push) begin
        q_lsb.push_back(w);
        q_msb.push_back(rev8(w));
      end
      drive_bit(k == 0, w[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (bl.idx !== 3'd0 || bl.dout !== 8'h00 || bl.dout_valid !== 1'b0 ||
        bl.overrun !== 1'b0 || bl.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s lsb: idx=%0d dout=%h v=%b ovr=%b ferr=%b, want all zero",
               tag, bl.idx, bl.dout, bl.dout_valid, bl.overrun, bl.frame_err);
    end
    total++;
    if (bm.idx !== 3'd0 || bm.dout !== 8'h00 || bm.dout_valid !== 1'b0 ||
        bm.overrun !== 1'b0 || bm.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s msb: idx=%0d dout=%h v=%b ovr=%b ferr=%b, want all zero",
               tag, bm.idx, bm.dout, bm.dout_valid, bm.overrun, bm.frame_err);
    end
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0);
    set_ready(1'b0);
    do_reset();
    check_idle("reset");
  endtask

  task automatic test_basic();
    set_ready(1'b1);
    send_word(8'hA5, 1'b1);
    total++;
    if (bl.dout !== 8'hA5 || bl.dout_valid !== 1'b1 || bl.idx !== 3'd0) begin
      bad++;
      $display("FAIL basic_out: dout=%h v=%b idx=%0d, want a5 1 0", bl.dout, bl.dout_valid, bl.idx);
    end
    tick();
    total++;
    if (bl.dout_valid !== 1'b0 || bm.dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain: v=%b/%b, want 0/0", bl.dout_valid, bm.dout_valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'hA5;
    set_ready(1'b1);
    for (int k = 0; k < 4; k++) drive_bit(k == 0, w[k]);
    for (int g = 0; g < 3; g++) begin
      set_in(1'b0, 1'b1, 1'b1);
      tick();
      total++;
      if (bl.idx !== 3'd4 || bl.frame_err !== 1'b0) begin
        bad++;
        $display("FAIL gap_hold: idx=%0d ferr=%b, want 4 0", bl.idx, bl.frame_err);
      end
    end
    set_in(1'b0, 1'b0, 1'b0);
    q_lsb.push_back(w);
    q_msb.push_back(rev8(w));
    for (int k = 4; k < 8; k++) drive_bit(1'b0, w[k]);
    total++;
    if (bl.dout !== 8'hA5 || bl.dout_valid !== 1'b1 || bl.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL gap_out: dout=%h v=%b ferr=%b, want a5 1 0", bl.dout, bl.dout_valid, bl.frame_err);
    end
    tick();
  endtask

  task automatic test_msb();
    set_ready(1'b1);
    send_word(8'hA5, 1'b1);
    total++;
    if (bm.dout !== 8'hA5) begin
      bad++;
      $display("FAIL msb_pal: dout=%h, want a5", bm.dout);
    end
    tick();
    send_word(8'h03, 1'b1);
    total++;
    if (bm.dout !== 8'hC0 || bl.dout !== 8'h03) begin
      bad++;
      $display("FAIL msb_c0: msb=%h lsb=%h, want c0 03", bm.dout, bl.dout);
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_ready(1'b0);
    send_word(8'h3C, 1'b1);
    total++;
    if (bl.dout !== 8'h3C || bl.dout_valid !== 1'b1 || bl.overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp_first: dout=%h v=%b ovr=%b, want 3c 1 0", bl.dout, bl.dout_valid, bl.overrun);
    end
    send_word(8'hF0, 1'b0);
    total++;
    if (bl.dout !== 8'h3C || bl.overrun !== 1'b1 || bm.overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovr: dout=%h ovr=%b/%b, want 3c 1/1", bl.dout, bl.overrun, bm.overrun);
    end
    set_ready(1'b1);
    tick();
    total++;
    if (bl.dout_valid !== 1'b0 || bl.dout !== 8'h3C || bl.overrun !== 1'b1) begin
      bad++;
      $display("FAIL bp_drain: v=%b dout=%h ovr=%b, want 0 3c 1", bl.dout_valid, bl.dout, bl.overrun);
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] w;
    do_reset();
    set_ready(1'b0);
    send_word(8'h11, 1'b1);
    w = 8'h22;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        set_ready(1'b1);
        q_lsb.push_back(w);
        q_msb.push_back(rev8(w));
      end
      drive_bit(k == 0, w[k]);
    end
    total++;
    if (bl.dout !== 8'h22 || bl.dout_valid !== 1'b1 || bl.overrun !== 1'b0) begin
      bad++;
      $display("FAIL same_edge: dout=%h v=%b ovr=%b, want 22 1 0", bl.dout, bl.dout_valid, bl.overrun);
    end
    tick();
    total++;
    if (bl.dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL same_edge_drain: v=%b, want 0", bl.dout_valid);
    end
  endtask

  task automatic test_mid_sof();
    logic [7:0] w;
    int pulses;
    w = 8'h81;
    pulses = 0;
    set_ready(1'b1);
    for (int k = 0; k < 5; k++) drive_bit(k == 0, 1'b1);
    drive_bit(1'b1, w[0]);
    if (bl.frame_err === 1'b1) pulses++;
    total++;
    if (bl.frame_err !== 1'b1 || bl.idx !== 3'd1) begin
      bad++;
      $display("FAIL sof_pulse: ferr=%b idx=%0d, want 1 1", bl.frame_err, bl.idx);
    end
    for (int k = 1; k < 8; k++) begin
      if (k == 7) begin
        q_lsb.push_back(w);
        q_msb.push_back(rev8(w));
      end
      drive_bit(1'b0, w[k]);
      if (bl.frame_err === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1 || bl.dout !== 8'h81) begin
      bad++;
      $display("FAIL sof_frame: pulses=%0d dout=%h, want 1 81", pulses, bl.dout);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    set_ready(1'b0);
    send_word(8'h5A, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(k == 0, 1'b1);
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    check_idle("rst_mid");
    set_ready(1'b1);
    send_word(8'hC3, 1'b1);
    total++;
    if (bl.dout !== 8'hC3 || bm.dout !== rev8(8'hC3) || bl.dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_next: lsb=%h msb=%h v=%b, want c3 c3 1", bl.dout, bm.dout, bl.dout_valid);
    end
    tick();
  endtask

  // Scoreboard: a transfer happens on the next rising edge when valid&&ready here.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bl.dout_valid === 1'b1 && bl.dout_ready === 1'b1) begin
        total++;
        if (q_lsb.size() == 0) begin
          bad++;
          $display("FAIL sb_lsb: unexpected word %h", bl.dout);
        end else begin
          e = q_lsb.pop_front();
          if (bl.dout !== e) begin
            bad++;
            $display("FAIL sb_lsb: got %h, want %h", bl.dout, e);
          end
        end
      end
      if (!rst && bm.dout_valid === 1'b1 && bm.dout_ready === 1'b1) begin
        total++;
        if (q_msb.size() == 0) begin
          bad++;
          $display("FAIL sb_msb: unexpected word %h", bm.dout);
        end else begin
          e = q_msb.pop_front();
          if (bm.dout !== e) begin
            bad++;
            $display("FAIL sb_msb: got %h, want %h", bm.dout, e);
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    set_ready(1'b0);
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_gapped();
    test_msb();
    test_backpressure();
    test_same_edge();
    test_mid_sof();
    test_rst_mid();
    tick();
    tick();
    total++;
    if (q_lsb.size() != 0 || q_msb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: lsb=%0d msb=%0d words never transferred", q_lsb.size(), q_msb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
